wb_debug_split: RTL and testbench

Parametrised Wishbone address splitter and debug register bank for the user project wrapper. It routes each slave cycle from the management SoC either to the user design or to an internal bank of DBG_REGS debug registers at the top of user address space. It adds a bus watchdog: a user-region cycle not acknowledged within TIMEOUT clocks is terminated with a fixed error word and counted. It sits between the wrapper's wbs_* ports and the user logic.

---
 rtl/wb_debug_split.sv | 120 ++++++++++++
 tb/tb_wb_debug_split.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_debug_split.sv
// wb_debug_split: routes Wishbone slave cycles to the user design or to a
// debug register bank, and terminates stalled user cycles via a watchdog.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   wbs_*_i / wbs_ack_o, _dat_o  Wishbone slave port from the management SoC
//   usr_cyc_o, usr_ack_i, _dat_i gated cycle and response of the user slave
//   dbg_regs_o                   flat debug register contents (reg k at [32k+:32])
//   timeout_o, to_cnt_o          sticky watchdog flag, saturating event count
//   clr_timeout_i                synchronous clear of timeout_o / to_cnt_o
module wb_debug_split #(
    parameter logic [31:0] DBG_BASE = 32'h300F_FFF8,
    parameter int          DBG_REGS = 2,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic                     usr_cyc_o,
    input  logic                     usr_ack_i,
    input  logic [31:0]              usr_dat_i,
    output logic [32*DBG_REGS-1:0]   dbg_regs_o,
    output logic                     timeout_o,
    output logic [7:0]               to_cnt_o,
    input  logic                     clr_timeout_i
);
    localparam int IW = $clog2(DBG_REGS);
    localparam int AW = IW + 2;
    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, DBG_ACK, USR_WAIT, TO_ACK, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   regs_q [DBG_REGS];
    logic [31:0]   regs_d [DBG_REGS];
    logic          timeout_q, timeout_d;
    logic [7:0]    to_cnt_q, to_cnt_d;
    logic          req;
    logic          hit;
    logic [IW-1:0] idx;
    logic          unused_adr;

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign hit        = wbs_adr_i[31:AW] == DBG_BASE[31:AW];
    assign idx        = wbs_adr_i[AW-1:2];
    assign unused_adr = ^wbs_adr_i[1:0];
    assign timeout_o  = timeout_q;
    assign to_cnt_o   = to_cnt_q;

    for (genvar k = 0; k < DBG_REGS; k++) begin : g_out
        assign dbg_regs_o[32*k +: 32] = regs_q[k];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            regs_q    <= '{default: '0};
            timeout_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
            timeout_q <= timeout_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // A user ack or a master abort takes priority over the watchdog limit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (req) state_d = hit ? DBG_ACK : USR_WAIT;
            DBG_ACK:  state_d = IDLE;
            USR_WAIT: if (usr_ack_i || !wbs_cyc_i) state_d = IDLE;
                      else if (cnt_q == LIMIT) state_d = TO_ACK;
            TO_ACK:   state_d = DRAIN;
            DRAIN:    if (!req) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = (state_q == USR_WAIT && state_d == USR_WAIT) ? cnt_q + 16'd1 : '0;
        regs_d  = regs_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && req && hit) begin
            if (wbs_we_i) begin
                for (int b = 0; b < 4; b++)
                    if (wbs_sel_i[b]) regs_d[idx][8*b +: 8] = wbs_dat_i[8*b +: 8];
            end else begin
                rdata_d = regs_q[idx];
            end
        end
        // A termination in the same cycle as a clear still counts as one event.
        timeout_d = state_q == TO_ACK ? 1'b1 : clr_timeout_i ? 1'b0 : timeout_q;
        to_cnt_d  = state_q == TO_ACK ? (clr_timeout_i ? 8'd1 : to_cnt_q + {7'd0, to_cnt_q != 8'hFF})
                  : clr_timeout_i ? 8'd0 : to_cnt_q;
    end

    always_comb begin
        usr_cyc_o = state_q == USR_WAIT && wbs_cyc_i;
        wbs_ack_o = state_q == DBG_ACK || state_q == TO_ACK || (state_q == USR_WAIT && usr_ack_i);
        wbs_dat_o = state_q == DBG_ACK  ? rdata_q
                  : state_q == TO_ACK   ? ERR_DATA
                  : state_q == USR_WAIT ? usr_dat_i : '0;
    end
endmodule

// File: tb/tb_wb_debug_split.sv
// tb_wb_debug_split: directed bench for wb_debug_split with a per-cycle
// expectation model (DBG_REGS=2, TIMEOUT=8).
module tb_wb_debug_split;
    localparam int T = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        usr_cyc_o;
    logic        usr_ack_i = 1'b0;
    logic [31:0] usr_dat_i = '0;
    logic [63:0] dbg_regs_o;
    logic        timeout_o;
    logic [7:0]  to_cnt_o;
    logic        clr_timeout_i = 1'b0;

    wb_debug_split #(.DBG_BASE(32'h300F_FFF8), .DBG_REGS(2), .TIMEOUT(T), .ERR_DATA(ERR)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .usr_cyc_o(usr_cyc_o), .usr_ack_i(usr_ack_i), .usr_dat_i(usr_dat_i),
        .dbg_regs_o(dbg_regs_o), .timeout_o(timeout_o), .to_cnt_o(to_cnt_o),
        .clr_timeout_i(clr_timeout_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          checks = 0, errors = 0;
    logic        chk_en = 1'b0;
    logic        e_ack = 1'b0, e_usr_cyc = 1'b0, e_dat_chk = 1'b1;
    logic [31:0] e_dat = '0;
    logic [31:0] m_regs [2] = '{32'h0, 32'h0};
    logic        m_to = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge wb_clk_i) if (chk_en) begin
        chk("ack", wbs_ack_o, e_ack);
        if (e_dat_chk) chk("dat", wbs_dat_o, e_dat);
        chk("usr_cyc", usr_cyc_o, e_usr_cyc);
        chk("timeout", timeout_o, m_to);
        chk("to_cnt", to_cnt_o, m_cnt);
        chk("regs", dbg_regs_o, {m_regs[1], m_regs[0]});
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic ex(input logic a, input logic [31:0] d, input logic u);
        e_ack = a;
        e_dat = d;
        e_usr_cyc = u;
    endtask

    task automatic dbg(input logic w, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] got);
        int i;
        i = int'(adr[2]);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = w; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        ex(0, 0, 0);
        tick();
        if (w) for (int b = 0; b < 4; b++) if (sel[b]) m_regs[i][8*b +: 8] = dat[8*b +: 8];
        ex(1, m_regs[i], 0);
        e_dat_chk = !w;
        @(negedge wb_clk_i);
        got = wbs_dat_o;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        tick();
        ex(0, 0, 0);
        e_dat_chk = 1;
    endtask

    // e counts edges since the request was sampled; e == T is the error-ack cycle.
    task automatic usr_txn(input logic [31:0] adr, input int ack_at, input int abort_at,
                           input logic clr, input logic [31:0] rd,
                           output int ack_e, output logic [31:0] ack_d);
        logic done;
        done = 0;
        ack_e = -1;
        ack_d = '0;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = adr; wbs_sel_i = 4'hF;
        ex(0, 0, 0);
        tick();
        for (int e = 0; e < T && !done; e++) begin
            usr_ack_i = (e == ack_at);
            usr_dat_i = usr_ack_i ? rd : 32'h5A5A_0000 + e;
            if (e == abort_at) wbs_cyc_i = 0;
            ex(usr_ack_i, usr_dat_i, wbs_cyc_i);
            @(negedge wb_clk_i);
            if (wbs_ack_o && ack_e < 0) begin ack_e = e; ack_d = wbs_dat_o; end
            tick();
            if (usr_ack_i || !wbs_cyc_i) begin
                usr_ack_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
                ex(0, 0, 0);
                done = 1;
            end
        end
        if (!done) begin
            usr_ack_i = 0;
            clr_timeout_i = clr;
            ex(1, ERR, 0);
            @(negedge wb_clk_i);
            if (wbs_ack_o && ack_e < 0) begin ack_e = T; ack_d = wbs_dat_o; end
            tick();
            clr_timeout_i = 0;
            m_to = 1;
            m_cnt = clr ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
            usr_ack_i = 1;
            usr_dat_i = 32'h7777_7777;
            ex(0, 0, 0);
            tick();
            usr_ack_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
            tick();
        end
    endtask

    task automatic clr_pulse();
        clr_timeout_i = 1;
        tick();
        clr_timeout_i = 0;
        m_to = 0;
        m_cnt = 0;
    endtask

    initial begin
        logic [31:0] got;
        int          ke;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_ack", wbs_ack_o, 0);
        chk("rst_dat", wbs_dat_o, 0);
        chk("rst_usr_cyc", usr_cyc_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_to_cnt", to_cnt_o, 0);
        chk("rst_regs", dbg_regs_o, 0);
        wb_rst_ni = 1;
        ex(0, 0, 0);
        chk_en = 1;
        tick();
        tick();

        dbg(1, 32'h300F_FFFC, 32'h1234_5678, 4'hF, got);
        chk("reg1_full", dbg_regs_o[63:32], 32'h1234_5678);
        dbg(1, 32'h300F_FFFC, 32'hAABB_CCDD, 4'b0101, got);
        chk("reg1_sel", dbg_regs_o[63:32], 32'h12BB_56DD);
        dbg(1, 32'h300F_FFF8, 32'h0F0F_A5A5, 4'b1010, got);
        chk("reg0_sel", dbg_regs_o[31:0], 32'h0F00_A500);
        dbg(0, 32'h300F_FFFE, 32'h0, 4'hF, got);
        chk("rd_reg1", got, 32'h12BB_56DD);
        dbg(0, 32'h300F_FFF9, 32'h0, 4'hF, got);
        chk("rd_reg0", got, 32'h0F00_A500);

        usr_txn(32'h3000_0010, 3, -1, 0, 32'hCAFE_0001, ke, got);
        chk("pass_dat", got, 32'hCAFE_0001);
        chk("pass_edge", ke, 3);
        usr_txn(32'h300F_FFF4, 0, -1, 0, 32'h0000_BEEF, ke, got);
        chk("below_win_dat", got, 32'h0000_BEEF);

        usr_txn(32'h3000_0020, -1, -1, 0, 32'h0, ke, got);
        chk("wd_edge", ke, 8);
        chk("wd_dat", got, 32'hDEAD_BEEF);
        chk("wd_flag", timeout_o, 1);
        chk("wd_cnt", to_cnt_o, 1);

        usr_txn(32'h3000_0030, T - 1, -1, 0, 32'h1357_9BDF, ke, got);
        chk("limit_ack_dat", got, 32'h1357_9BDF);
        chk("limit_cnt", to_cnt_o, 1);
        usr_txn(32'h3000_0040, -1, 4, 0, 32'h0, ke, got);
        chk("abort_no_ack", ke, -1);
        chk("abort_cnt", to_cnt_o, 1);

        usr_txn(32'h3000_0050, -1, -1, 0, 32'h0, ke, got);
        chk("cnt_two", to_cnt_o, 2);
        clr_pulse();
        tick();
        chk("clr_flag", timeout_o, 0);
        chk("clr_cnt", to_cnt_o, 0);
        usr_txn(32'h3000_0060, -1, -1, 0, 32'h0, ke, got);
        usr_txn(32'h3000_0060, -1, -1, 0, 32'h0, ke, got);
        usr_txn(32'h3000_0060, -1, -1, 1, 32'h0, ke, got);
        chk("clr_coincident", to_cnt_o, 1);

        for (int n = 0; n < 300; n++) usr_txn(32'h3000_0070, -1, -1, 0, 32'h0, ke, got);
        chk("saturate", to_cnt_o, 255);

        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h300F_FFFC;
        ex(0, 0, 0);
        tick();
        ex(1, m_regs[1], 0);
        chk("pre_rst_ack", wbs_ack_o, 1);
        chk_en = 0;
        #2 wb_rst_ni = 0;
        #1;
        chk("mid_rst_ack", wbs_ack_o, 0);
        chk("mid_rst_dat", wbs_dat_o, 0);
        chk("mid_rst_regs", dbg_regs_o, 0);
        chk("mid_rst_cnt", to_cnt_o, 0);
        chk("mid_rst_flag", timeout_o, 0);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        m_regs = '{32'h0, 32'h0};
        m_to = 0;
        m_cnt = 0;
        tick();
        tick();
        wb_rst_ni = 1;
        ex(0, 0, 0);
        chk_en = 1;
        tick();
        dbg(0, 32'h300F_FFFC, 32'h0, 4'hF, got);
        chk("post_rst_rd", got, 32'h0);
        tick();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
